// File: rtl/ysyx_24110026_wbu.sv
// Writeback unit: retires ALU results or waits for load data, then writes the regfile for one cycle.
// Optional feature macro: YSYX_24110026_WBU_MISALIGN_EN (flags misaligned LH/LHU/LW instead of writing).
module ysyx_24110026_wbu (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_rd,
   input  logic [31:0] in_data,
   input  logic        in_is_load,
   input  logic [2:0]  in_funct3,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        rf_en,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        wb_done,
   output logic        busy,
   output logic [4:0]  busy_rd,
   output logic        wb_misalign
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      WRITE     = 2'd2
   } state_e;

   state_e      state_q;
   logic [4:0]  rd_q;
   logic [1:0]  off_q;
   logic [2:0]  f3_q;
   logic        rf_en_q;
   logic [4:0]  waddr_q;
   logic [31:0] wdata_q;
   logic        done_q;
   logic        mis_q;

   logic [7:0]  byte_d;
   logic [15:0] half_d;
   logic [31:0] load_data_d;
   logic        load_mis_d;

   assign in_ready    = (state_q == IDLE) & ~rst;
   assign busy        = (state_q != IDLE);
   assign busy_rd     = busy ? rd_q : '0;
   assign rf_en       = rf_en_q;
   assign rf_waddr    = waddr_q;
   assign rf_wdata    = wdata_q;
   assign wb_done     = done_q;
   assign wb_misalign = mis_q;

   // Lane selection from the latched byte offset of the load address.
   always_comb begin
      byte_d      = '0;
      half_d      = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      load_data_d = '0;
      case (off_q)
         2'd0: byte_d = mem_rdata[7:0];
         2'd1: byte_d = mem_rdata[15:8];
         2'd2: byte_d = mem_rdata[23:16];
         default: byte_d = mem_rdata[31:24];
      endcase
      case (f3_q)
         3'b000: load_data_d = {{24{byte_d[7]}}, byte_d};
         3'b100: load_data_d = {24'h0, byte_d};
         3'b001: load_data_d = {{16{half_d[15]}}, half_d};
         3'b101: load_data_d = {16'h0, half_d};
         3'b010: load_data_d = mem_rdata;
         default: load_data_d = '0;
      endcase
`ifdef YSYX_24110026_WBU_MISALIGN_EN
      load_mis_d = ((f3_q[1:0] == 2'b01) && off_q[0]) ||
                   ((f3_q == 3'b010) && (off_q != 2'd0));
`else
      load_mis_d = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rd_q    <= '0;
         off_q   <= '0;
         f3_q    <= '0;
         rf_en_q <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  rd_q <= in_rd;
                  if (in_is_load) begin
                     off_q   <= in_data[1:0];
                     f3_q    <= in_funct3;
                     state_q <= LOAD_WAIT;
                  end else begin
                     waddr_q <= in_rd;
                     wdata_q <= in_data;
                     rf_en_q <= (in_rd != 5'd0);
                     done_q  <= 1'b1;
                     mis_q   <= 1'b0;
                     state_q <= WRITE;
                  end
               end
            end
            LOAD_WAIT: begin
               if (mem_rvalid) begin
                  waddr_q <= rd_q;
                  wdata_q <= load_data_d;
                  rf_en_q <= (rd_q != 5'd0) & ~load_mis_d;
                  mis_q   <= load_mis_d;
                  done_q  <= 1'b1;
                  state_q <= WRITE;
               end
            end
            WRITE: begin
               rf_en_q <= 1'b0;
               done_q  <= 1'b0;
               mis_q   <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_24110026_wbu.sv
// Directed self-checking bench for ysyx_24110026_wbu; honours YSYX_24110026_WBU_MISALIGN_EN if defined.
module tb_ysyx_24110026_wbu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic [31:0] in_data;
   logic        in_is_load;
   logic [2:0]  in_funct3;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rf_en;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        wb_done;
   logic        busy;
   logic [4:0]  busy_rd;
   logic        wb_misalign;

   int unsigned passed = 0;
   int unsigned total  = 0;

   always #5 clk = ~clk;

   ysyx_24110026_wbu dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rd(in_rd), .in_data(in_data), .in_is_load(in_is_load), .in_funct3(in_funct3),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rf_en(rf_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .wb_done(wb_done), .busy(busy), .busy_rd(busy_rd), .wb_misalign(wb_misalign)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one descriptor for a single edge; the DUT is expected to be IDLE.
   task automatic send(input logic [4:0] rd, input logic [31:0] data,
                       input logic is_load, input logic [2:0] f3);
      in_valid   = 1'b1;
      in_rd      = rd;
      in_data    = data;
      in_is_load = is_load;
      in_funct3  = f3;
      tick();
      in_valid   = 1'b0;
   endtask

   task automatic respond(input logic [31:0] word);
      mem_rvalid = 1'b1;
      mem_rdata  = word;
      tick();
      mem_rvalid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0; in_is_load = 1'b0;
      in_funct3 = '0; mem_rvalid = 1'b0; mem_rdata = '0;
      tick(); tick();
      check("rst_in_ready", {31'h0, in_ready}, 32'h0);
      check("rst_rf_en",    {31'h0, rf_en},    32'h0);
      check("rst_wb_done",  {31'h0, wb_done},  32'h0);
      check("rst_busy",     {31'h0, busy},     32'h0);
      check("rst_wdata",    rf_wdata,          32'h0);
      check("rst_misalign", {31'h0, wb_misalign}, 32'h0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", {31'h0, in_ready}, 32'h1);

      // ALU writeback
      send(5'd5, 32'h1234_5678, 1'b0, 3'b000);
      check("alu_rf_en",   {31'h0, rf_en},   32'h1);
      check("alu_waddr",   {27'h0, rf_waddr}, 32'd5);
      check("alu_wdata",   rf_wdata,         32'h1234_5678);
      check("alu_done",    {31'h0, wb_done}, 32'h1);
      check("alu_ready0",  {31'h0, in_ready}, 32'h0);
      check("alu_busy_rd", {27'h0, busy_rd}, 32'd5);
      tick();
      check("alu_ready1",  {31'h0, in_ready}, 32'h1);
      check("alu_done_off",{31'h0, wb_done}, 32'h0);
      check("alu_en_off",  {31'h0, rf_en},   32'h0);

      // Stray response while idle must be ignored
      respond(32'hFFFF_FFFF);
      check("idle_rvalid_done", {31'h0, wb_done}, 32'h0);
      check("idle_rvalid_busy", {31'h0, busy},    32'h0);

      // LB at offset 3 with three wait cycles
      send(5'd7, 32'h0000_1003, 1'b1, 3'b000);
      check("lb_wait_ready", {31'h0, in_ready}, 32'h0);
      check("lb_busy_rd",    {27'h0, busy_rd},  32'd7);
      tick(); tick(); tick();
      check("lb_wait_done",  {31'h0, wb_done},  32'h0);
      check("lb_wait_ready2",{31'h0, in_ready}, 32'h0);
      respond(32'h80FF_7F01);
      check("lb_rf_en",  {31'h0, rf_en},    32'h1);
      check("lb_waddr",  {27'h0, rf_waddr}, 32'd7);
      check("lb_wdata",  rf_wdata,          32'hFFFF_FF80);
      check("lb_done",   {31'h0, wb_done},  32'h1);
      tick();

      // LHU upper half
      send(5'd9, 32'h0000_2002, 1'b1, 3'b101);
      respond(32'hBEEF_1234);
      check("lhu_wdata", rf_wdata, 32'h0000_BEEF);
      tick();

      // LH lower half, negative
      send(5'd10, 32'h0000_3000, 1'b1, 3'b001);
      respond(32'h1234_8001);
      check("lh_wdata", rf_wdata, 32'hFFFF_8001);
      tick();

      // LBU offset 1
      send(5'd11, 32'h0000_4001, 1'b1, 3'b100);
      respond(32'h0000_9A00);
      check("lbu_wdata", rf_wdata, 32'h0000_009A);
      tick();

      // Reserved funct3 writes zero
      send(5'd12, 32'h0000_5000, 1'b1, 3'b011);
      respond(32'h5555_5555);
      check("rsv_wdata", rf_wdata, 32'h0);
      check("rsv_rf_en", {31'h0, rf_en}, 32'h1);
      tick();

      // x0 target: no write, still retires
      send(5'd0, 32'hDEAD_BEEF, 1'b0, 3'b000);
      check("x0_rf_en", {31'h0, rf_en},   32'h0);
      check("x0_done",  {31'h0, wb_done}, 32'h1);
      tick();

      // Reset while waiting for load data
      send(5'd13, 32'h0000_6000, 1'b1, 3'b010);
      check("ml_busy", {31'h0, busy}, 32'h1);
      rst = 1'b1;
      tick();
      check("ml_rst_busy",  {31'h0, busy},     32'h0);
      check("ml_rst_ready", {31'h0, in_ready}, 32'h0);
      rst = 1'b0;
      respond(32'hAAAA_AAAA);
      check("ml_rf_en", {31'h0, rf_en},   32'h0);
      check("ml_done",  {31'h0, wb_done}, 32'h0);
      check("ml_busy2", {31'h0, busy},    32'h0);

      // Misaligned LW
      send(5'd14, 32'h0000_7001, 1'b1, 3'b010);
      respond(32'hCAFE_F00D);
      check("mis_done", {31'h0, wb_done}, 32'h1);
`ifdef YSYX_24110026_WBU_MISALIGN_EN
      check("mis_flag",  {31'h0, wb_misalign}, 32'h1);
      check("mis_rf_en", {31'h0, rf_en},       32'h0);
`else
      check("mis_flag",  {31'h0, wb_misalign}, 32'h0);
      check("mis_rf_en", {31'h0, rf_en},       32'h1);
      check("mis_wdata", rf_wdata,             32'hCAFE_F00D);
`endif
      tick();
      check("mis_flag_off", {31'h0, wb_misalign}, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ysyx_24110026_wbu.md
YSYX_24110026_WBU -- requirements
Module: ysyx_24110026_wbu

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1: EXU result/descriptor valid.
REQ-004 SHALL have port in_ready, output, 1: WBU can accept; it is (state==IDLE) & ~rst.
REQ-005 SHALL have port in_rd, input, 5: destination register index.
REQ-006 SHALL have port in_data, input, 32: ALU result, or load byte address when in_is_load=1.
REQ-007 SHALL have port in_is_load, input, 1: descriptor is a load.
REQ-008 SHALL have port in_funct3, input, 3: load type; ignored for non-loads.
REQ-009 SHALL have port mem_rvalid, input, 1: load data response strobe.
REQ-010 SHALL have port mem_rdata, input, 32: aligned 32-bit word containing the load target.
REQ-011 SHALL have port rf_en, output, 1: regfile write enable.
REQ-012 SHALL have port rf_waddr, output, 5: regfile write address.
REQ-013 SHALL have port rf_wdata, output, 32: regfile write data.
REQ-014 SHALL have port wb_done, output, 1: one-cycle pulse per retired descriptor.
REQ-015 SHALL have port busy, output, 1: a descriptor is held (state != IDLE).
REQ-016 SHALL have port busy_rd, output, 5: rd of the held descriptor, for decode hazard stall.
REQ-017 SHALL have port wb_misalign, output, 1: misaligned-load flag, tied 0 when the feature is compiled out.

Function
REQ-018 SHALL implement FSM IDLE, LOAD_WAIT, WRITE; accept occurs when in_valid & in_ready.
REQ-019 SHALL, on accept of a non-load in IDLE, latch rd and in_data and go to WRITE.
REQ-020 SHALL, on accept of a load in IDLE, latch rd, in_data[1:0] and funct3 and go to LOAD_WAIT.
REQ-021 SHALL, in LOAD_WAIT, hold in_ready=0 until mem_rvalid=1, then latch the extracted data and go to WRITE.
REQ-022 SHALL ignore mem_rvalid in any state other than LOAD_WAIT.
REQ-023 SHALL, in WRITE, assert wb_done=1 and rf_en=(rd!=0) for exactly one cycle, then return to IDLE.
REQ-024 SHALL drive rf_waddr and rf_wdata from registers, stable for the whole WRITE cycle.
REQ-025 SHALL give latency: a non-load accepted in cycle N is written in N+1; a load response in cycle M is written in M+1.
REQ-026 SHALL give a throughput of at most one descriptor per 2 cycles, because in_ready=0 during WRITE.
REQ-027 SHALL extract load data by funct3 and offset a=addr[1:0]:
- 000 LB: sign-extended byte a.
- 100 LBU: zero-extended byte a.
- 001 LH: sign-extended half addr[1].
- 101 LHU: zero-extended half addr[1].
- 010 LW: full word.
- 011, 110, 111: write 0.
REQ-028 SHALL suppress the regfile write for rd=0 while still pulsing wb_done.

Reset
REQ-029 SHALL, with rst=1 at a clock edge, force state IDLE and clear rf_en, rf_waddr, rf_wdata, wb_done, busy, busy_rd and wb_misalign to 0.
REQ-030 SHALL, on reset mid-load, drop the held load with no write; a later mem_rvalid is ignored by REQ-022.
REQ-031 SHALL hold in_ready=0 while rst=1 and raise it to 1 in the first cycle after reset deasserts.

Configuration
REQ-032 SHALL treat YSYX_24110026_WBU_MISALIGN_EN as the single compile-time feature macro.
REQ-033 SHALL, when YSYX_24110026_WBU_MISALIGN_EN is defined, classify LH/LHU with addr[0]=1 and LW with addr[1:0]!=0 as misaligned.
REQ-034 SHALL, for a misaligned load, in WRITE drive rf_en=0, wb_misalign=1 and wb_done=1.
REQ-035 SHALL, when YSYX_24110026_WBU_MISALIGN_EN is undefined, ignore addr[0] for halfwords and addr[1:0] for words, and hold wb_misalign at 0.

Verification
REQ-036 SHALL be verified by ALU writeback: accept rd=5, data=0x12345678 -> next cycle rf_en=1, waddr=5, wdata=0x12345678, wb_done=1; in_ready=1 the following cycle.
REQ-037 SHALL be verified by LB sign extension: load addr=0x...03, funct3=000, 3-cycle wait, rdata=0x80FF7F01 -> rf_wdata=0xFFFFFF80 one cycle after rvalid.
REQ-038 SHALL be verified by LHU: addr=0x...02, funct3=101, rdata=0xBEEF1234 -> rf_wdata=0x0000BEEF.
REQ-039 SHALL be verified by x0 target: accept rd=0, data=0xDEADBEEF -> rf_en=0, wb_done=1.
REQ-040 SHALL be verified by reset mid-load: rst in LOAD_WAIT, then rvalid -> no rf_en, no wb_done, busy=0.
REQ-041 SHALL be verified by misaligned LW at addr=0x...01: with the macro, wb_misalign=1 and rf_en=0; without it, rf_wdata=rdata.
